// File: rtl/iff_strobe_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | iff_strobe_gen                                                             |
// | Programmable clock-enable strobe generator with burst, hold and abort.     |
// | Optional feature macro: IFF_STROBE_GEN_PHASE_EN (adds a first-strobe phase |
// | offset input).                                                             |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module iff_strobe_gen #(
  parameter int DIV_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [DIV_W-1:0] period,
  input  logic [CNT_W-1:0] burst,
  input  logic             hold,
`ifdef IFF_STROBE_GEN_PHASE_EN
  input  logic [DIV_W-1:0] phase,
`endif
  output logic             en_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] strobe_cnt
);

  // One extra divider bit so period-1+phase cannot overflow.
  localparam int C_DIV_EXT_W = DIV_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [C_DIV_EXT_W-1:0] r_div;
  logic [C_DIV_EXT_W-1:0] w_div_nxt;
  logic [DIV_W-1:0]       r_period;
  logic [DIV_W-1:0]       w_period_nxt;
  logic [CNT_W-1:0]       r_burst;
  logic [CNT_W-1:0]       w_burst_nxt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic [CNT_W-1:0]       w_cnt_inc;
  logic                   w_en_nxt;
  logic [DIV_W-1:0]       w_period_eff;
  logic [C_DIV_EXT_W-1:0] w_load;
  logic [C_DIV_EXT_W-1:0] w_reload;

  assign w_period_eff = (period == '0) ? DIV_W'(1) : period;
  assign w_reload     = {1'b0, r_period} - C_DIV_EXT_W'(1);
  assign w_cnt_inc    = strobe_cnt + CNT_W'(1);

`ifdef IFF_STROBE_GEN_PHASE_EN
  assign w_load = {1'b0, w_period_eff} - C_DIV_EXT_W'(1) + {1'b0, phase};
`else
  assign w_load = {1'b0, w_period_eff} - C_DIV_EXT_W'(1);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_div      <= '0;
      r_period   <= DIV_W'(1);
      r_burst    <= '0;
      strobe_cnt <= '0;
      en_out     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_div      <= w_div_nxt;
      r_period   <= w_period_nxt;
      r_burst    <= w_burst_nxt;
      strobe_cnt <= w_cnt_nxt;
      en_out     <= w_en_nxt;
      busy       <= (w_state_nxt == S_RUN);
      done       <= (w_state_nxt == S_DONE);
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_div_nxt    = r_div;
    w_period_nxt = r_period;
    w_burst_nxt  = r_burst;
    w_cnt_nxt    = strobe_cnt;
    w_en_nxt     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !stop) begin
          w_period_nxt = w_period_eff;
          w_burst_nxt  = burst;
          w_div_nxt    = w_load;
          w_cnt_nxt    = '0;
          w_state_nxt  = S_RUN;
        end
      end
      S_RUN: begin
        // Abort wins over a coincident strobe.
        if (stop) begin
          w_state_nxt = S_IDLE;
        end else if (!hold) begin
          if (r_div == '0) begin
            w_div_nxt = w_reload;
            w_en_nxt  = 1'b1;
            w_cnt_nxt = w_cnt_inc;
            if ((r_burst != '0) && (w_cnt_inc == r_burst)) begin
              w_state_nxt = S_DONE;
            end
          end else begin
            w_div_nxt = r_div - C_DIV_EXT_W'(1);
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_iff_strobe_gen.sv
`default_nettype none
// Testbench for iff_strobe_gen: per-cycle vector table plus async-reset sequence.
module tb_iff_strobe_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, stop, hold;
  logic [7:0] period, burst, phase;
  logic       en_out, busy, done;
  logic [7:0] strobe_cnt;

  int n_vec = 0;
  int n_err = 0;

  iff_strobe_gen #(.DIV_W(8), .CNT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .period     (period),
    .burst      (burst),
    .hold       (hold),
`ifdef IFF_STROBE_GEN_PHASE_EN
    .phase      (phase),
`endif
    .en_out     (en_out),
    .busy       (busy),
    .done       (done),
    .strobe_cnt (strobe_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       st, sp, hd;
    logic [7:0] per, bur, ph;
    logic       en, bsy, dn;
    logic [7:0] cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int n, input logic st, input logic sp, input logic hd,
                     input logic [7:0] per, input logic [7:0] bur, input logic [7:0] ph,
                     input logic en, input logic bsy, input logic dn, input logic [7:0] cnt);
    vec_t v;
    v.st = st; v.sp = sp; v.hd = hd; v.per = per; v.bur = bur; v.ph = ph;
    v.en = en; v.bsy = bsy; v.dn = dn; v.cnt = cnt;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  // Packed compare of {en_out, busy, done, strobe_cnt}.
  task automatic chk(input string name, input int idx, input logic [10:0] exp);
    logic [10:0] act;
    act = {en_out, busy, done, strobe_cnt};
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s #%0d: got en/busy/done/cnt=%b/%b/%b/%0d required %b/%b/%b/%0d",
               name, idx, act[10], act[9], act[8], act[7:0],
               exp[10], exp[9], exp[8], exp[7:0]);
    end
  endtask

  initial begin
    rst = 1'b1; start = 0; stop = 0; hold = 0; period = 0; burst = 0; phase = 0;

    // period=4 burst=3, start re-asserted during RUN must be ignored
    add(2, 0,0,0, 8'd0, 8'd0, 8'd0, 0,0,0, 8'd0);
    add(1, 1,0,0, 8'd4, 8'd3, 8'd0, 0,1,0, 8'd0);
    add(3, 1,0,0, 8'd1, 8'd0, 8'd0, 0,1,0, 8'd0);
    add(1, 0,0,0, 8'd0, 8'd0, 8'd0, 1,1,0, 8'd1);
    add(3, 0,0,0, 8'd0, 8'd0, 8'd0, 0,1,0, 8'd1);
    add(1, 0,0,0, 8'd0, 8'd0, 8'd0, 1,1,0, 8'd2);
    add(3, 0,0,0, 8'd0, 8'd0, 8'd0, 0,1,0, 8'd2);
    add(1, 0,0,0, 8'd0, 8'd0, 8'd0, 1,0,1, 8'd3);
    add(1, 0,0,0, 8'd0, 8'd0, 8'd0, 0,0,0, 8'd3);
    // period=0 -> 1, burst=2; count then holds in IDLE
    add(1, 1,0,0, 8'd0, 8'd2, 8'd0, 0,1,0, 8'd0);
    add(1, 0,0,0, 8'd0, 8'd0, 8'd0, 1,1,0, 8'd1);
    add(1, 0,0,0, 8'd0, 8'd0, 8'd0, 1,0,1, 8'd2);
    add(3, 0,0,0, 8'd0, 8'd0, 8'd0, 0,0,0, 8'd2);
    // start together with stop in IDLE is not accepted
    add(2, 1,1,0, 8'd5, 8'd1, 8'd0, 0,0,0, 8'd2);
    // period=3 continuous, hold 5 cycles after first strobe, then stop
    add(1, 1,0,0, 8'd3, 8'd0, 8'd0, 0,1,0, 8'd0);
    add(2, 0,0,0, 8'd0, 8'd0, 8'd0, 0,1,0, 8'd0);
    add(1, 0,0,0, 8'd0, 8'd0, 8'd0, 1,1,0, 8'd1);
    add(5, 0,0,1, 8'd0, 8'd0, 8'd0, 0,1,0, 8'd1);
    add(2, 0,0,0, 8'd0, 8'd0, 8'd0, 0,1,0, 8'd1);
    add(1, 0,0,0, 8'd0, 8'd0, 8'd0, 1,1,0, 8'd2);
    add(2, 0,0,0, 8'd0, 8'd0, 8'd0, 0,1,0, 8'd2);
    add(1, 0,0,0, 8'd0, 8'd0, 8'd0, 1,1,0, 8'd3);
    add(1, 0,1,0, 8'd0, 8'd0, 8'd0, 0,0,0, 8'd3);
    // period=2 continuous, stop on the strobe edge
    add(1, 1,0,0, 8'd2, 8'd0, 8'd0, 0,1,0, 8'd0);
    add(1, 0,0,0, 8'd0, 8'd0, 8'd0, 0,1,0, 8'd0);
    add(1, 0,0,0, 8'd0, 8'd0, 8'd0, 1,1,0, 8'd1);
    add(1, 0,0,0, 8'd0, 8'd0, 8'd0, 0,1,0, 8'd1);
    add(1, 0,1,0, 8'd0, 8'd0, 8'd0, 0,0,0, 8'd1);
    add(2, 0,0,0, 8'd0, 8'd0, 8'd0, 0,0,0, 8'd1);
    // burst=1 with period=1: strobe and done on the first edge
    add(1, 1,0,0, 8'd1, 8'd1, 8'd0, 0,1,0, 8'd0);
    add(1, 0,0,0, 8'd0, 8'd0, 8'd0, 1,0,1, 8'd1);
    add(1, 0,0,0, 8'd0, 8'd0, 8'd0, 0,0,0, 8'd1);
    // period=1 continuous: strobe every cycle, 8-bit count wraps
    add(1, 1,0,0, 8'd1, 8'd0, 8'd0, 0,1,0, 8'd0);
    for (int k = 1; k <= 258; k++)
      add(1, 0,0,0, 8'd0, 8'd0, 8'd0, 1,1,0, 8'(k));
    add(1, 0,1,0, 8'd0, 8'd0, 8'd0, 0,0,0, 8'd2);
`ifdef IFF_STROBE_GEN_PHASE_EN
    // period=4 phase=2 burst=3: strobes at N+6, N+10, N+14
    add(1, 1,0,0, 8'd4, 8'd3, 8'd2, 0,1,0, 8'd0);
    add(5, 0,0,0, 8'd0, 8'd0, 8'd0, 0,1,0, 8'd0);
    add(1, 0,0,0, 8'd0, 8'd0, 8'd0, 1,1,0, 8'd1);
    add(3, 0,0,0, 8'd0, 8'd0, 8'd0, 0,1,0, 8'd1);
    add(1, 0,0,0, 8'd0, 8'd0, 8'd0, 1,1,0, 8'd2);
    add(3, 0,0,0, 8'd0, 8'd0, 8'd0, 0,1,0, 8'd2);
    add(1, 0,0,0, 8'd0, 8'd0, 8'd0, 1,0,1, 8'd3);
    add(1, 0,0,0, 8'd0, 8'd0, 8'd0, 0,0,0, 8'd3);
`endif

    #1;
    chk("reset_state", 0, 11'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      start = vecs[i].st; stop = vecs[i].sp; hold = vecs[i].hd;
      period = vecs[i].per; burst = vecs[i].bur; phase = vecs[i].ph;
      @(posedge clk);
      #1;
      chk("table", i, {vecs[i].en, vecs[i].bsy, vecs[i].dn, vecs[i].cnt});
    end

    // Asynchronous reset in the middle of a run, away from any clock edge
    start = 1; stop = 0; hold = 0; period = 8'd4; burst = 8'd3; phase = 8'd0;
    @(posedge clk);
    #1;
    start = 0;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk);
      #1;
    end
    chk("pre_reset_run", 0, {1'b0, 1'b1, 1'b0, 8'd1});
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset", 0, 11'd0);
    @(negedge clk);
    rst = 1'b0;

    // Restart right after reset: must match the period=4 burst=3 timeline
    start = 1; period = 8'd4; burst = 8'd3;
    for (int c = 0; c <= 13; c++) begin
      logic [7:0] ec;
      logic       ee, eb, ed;
      @(posedge clk);
      #1;
      start = 0;
      ec = (c >= 12) ? 8'd3 : 8'(c / 4);
      ee = (c > 0) && (c <= 12) && (c % 4 == 0);
      eb = (c < 12);
      ed = (c == 12);
      chk("post_reset_run", c, {ee, eb, ed, ec});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/iff_strobe_gen.md
IFF_STROBE_GEN -- requirements
Module: iff_strobe_gen

Interface
REQ-001 The block SHALL have parameter DIV_W, default 8, giving the period field width in bits.
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the burst and strobe-count width in bits.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on posedge clk.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: request to begin strobing, sampled in IDLE only.
REQ-006 The block SHALL have port stop, input, 1 bit: abort request.
REQ-007 The block SHALL have port period, input, DIV_W bits: strobe period in clocks, sampled on an accepted start.
REQ-008 The block SHALL have port burst, input, CNT_W bits: strobes per run, sampled on an accepted start; 0 means continuous.
REQ-009 The block SHALL have port hold, input, 1 bit: freezes the divider while high.
REQ-010 The block SHALL have port en_out, output, 1 bit: registered single-cycle enable strobe, the qualifier for consumers clocked as posedge clk iff en_out.
REQ-011 The block SHALL have port busy, output, 1 bit: high while in RUN.
REQ-012 The block SHALL have port done, output, 1 bit: single-cycle pulse at the end of a completed burst.
REQ-013 The block SHALL have port strobe_cnt, output, CNT_W bits: number of strobes issued in the current or last run.

Function
REQ-014 The state machine SHALL have states IDLE, RUN and DONE.
REQ-015 In IDLE with start=1 and stop=0 at an edge, the block SHALL latch period_r = max(period,1) and burst_r = burst, load the divider with period_r-1, clear strobe_cnt, and enter RUN.
REQ-016 In RUN with hold=0, the divider SHALL decrement each edge; at the edge where it equals 0 it SHALL reload period_r-1, set en_out=1 for exactly one cycle, and increment strobe_cnt.
REQ-017 The first strobe SHALL be visible period_r cycles after the accepting edge: with start accepted at edge N, en_out is high between edges N+period_r and N+period_r+1.
REQ-018 With period_r=1, en_out SHALL be high on every cycle of RUN while hold=0.
REQ-019 In RUN with hold=1, the divider and strobe_cnt SHALL be frozen and en_out SHALL be 0; counting SHALL resume from the frozen value when hold returns to 0.
REQ-020 When burst_r≠0 and a strobe brings strobe_cnt to burst_r, the block SHALL go to DONE at that same edge; that final strobe SHALL still be issued.
REQ-021 DONE SHALL last one cycle with done=1 and busy=0, then return to IDLE.
REQ-022 In RUN, stop=1 SHALL force IDLE at the next edge with en_out=0 and no done pulse; if stop and a strobe coincide, stop SHALL win and no strobe is issued.
REQ-023 Start SHALL be ignored outside IDLE; start and stop together in IDLE SHALL leave the block in IDLE.
REQ-024 strobe_cnt SHALL hold its value in IDLE until the next accepted start.
REQ-025 In continuous mode, strobe_cnt SHALL wrap modulo 2^CNT_W.
REQ-026 busy SHALL equal (state==RUN), registered.

Reset
REQ-027 Asserting rst SHALL immediately force state=IDLE, en_out=0, busy=0, done=0, strobe_cnt=0, divider=0, period_r=1, burst_r=0, with no dependence on clk.
REQ-028 A reset during RUN SHALL abort the run with no done pulse; the first edge after deassertion SHALL behave as IDLE.

Configuration
REQ-029 Macro IFF_STROBE_GEN_PHASE_EN, when defined, SHALL add input phase (DIV_W bits), sampled with start; the first strobe then occurs period_r+phase cycles after the accepting edge, and later strobes keep spacing period_r.
REQ-030 When IFF_STROBE_GEN_PHASE_EN is undefined, there SHALL be no phase port and the timing SHALL be exactly as in REQ-017.

Verification
REQ-031 Test: period=4, burst=3, start at edge 10 -> en_out high after edges 14, 18 and 22; done high after edge 22; strobe_cnt=3; busy low after edge 22.
REQ-032 Test: period=0, burst=2 -> treated as period 1; strobes after edges N+1 and N+2; then done.
REQ-033 Test: period=3, burst=0, hold high for 5 cycles after the first strobe -> next strobe is delayed by exactly 5 cycles; strobe_cnt keeps counting without a done pulse.
REQ-034 Test: period=2, burst=0, stop asserted on a strobe edge -> no strobe on that edge; IDLE; done never asserted.
REQ-035 Test: rst asserted mid-run with no clock edge -> all outputs 0 at once; a new start afterwards behaves as REQ-031.
REQ-036 Test: with IFF_STROBE_GEN_PHASE_EN, period=4, phase=2 -> strobes at N+6, N+10, N+14.
